// File: rtl/hex_rotate_monitor.sv
// hex_rotate_monitor
//   Samples four active-low 7-segment digit codes on each tick and decodes
//   them to symbols. Each new frame is compared with the previous one and
//   classified as static, rotate-right, rotate-left or jump. A small FSM
//   tracks runs of same-direction rotations and asserts locked after four
//   in a row. All outputs are registered one clk after the tick cycle.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   tick              sample strobe; hex_in is ignored when low
//   hex_in[27:0]      {HEX3,HEX2,HEX1,HEX0}, each bit6..0 = g..a, active low
//   sym3..sym0        decoded symbols (0x00-0x0F hex, 0x10 blank, 0x1F bad)
//   frame_valid       one-clk pulse per sampled frame
//   rot_r/rot_l/jump  one-clk classification pulses, coincident with frame_valid
//   bad_code          level, last frame held an undecodable digit
//   locked            level, steady rotation detected
//   phase[1:0]        digit offset relative to the first captured frame
//   rot_count[7:0]    rotations in either direction since reset (wraps)
module hex_rotate_monitor (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [27:0] hex_in,
  output logic [4:0]  sym3,
  output logic [4:0]  sym2,
  output logic [4:0]  sym1,
  output logic [4:0]  sym0,
  output logic        frame_valid,
  output logic        rot_r,
  output logic        rot_l,
  output logic        jump,
  output logic        bad_code,
  output logic        locked,
  output logic [1:0]  phase,
  output logic [7:0]  rot_count
);

  typedef enum logic [1:0] {EMPTY, TRACK, LOCKED, ERROR} state_t;

  state_t      state, state_nx;
  logic [1:0]  streak, streak_nx;
  logic        dir, dir_nx;          // direction of the current run, 1 = right
  logic [27:0] prev;

  function automatic logic [4:0] dec7(input logic [6:0] c);
    case (c)
      7'h40: dec7 = 5'h00;
      7'h79: dec7 = 5'h01;
      7'h24: dec7 = 5'h02;
      7'h30: dec7 = 5'h03;
      7'h19: dec7 = 5'h04;
      7'h12: dec7 = 5'h05;
      7'h02: dec7 = 5'h06;
      7'h78: dec7 = 5'h07;
      7'h00: dec7 = 5'h08;
      7'h10: dec7 = 5'h09;
      7'h08: dec7 = 5'h0A;
      7'h03: dec7 = 5'h0B;
      7'h46: dec7 = 5'h0C;
      7'h21: dec7 = 5'h0D;
      7'h06: dec7 = 5'h0E;
      7'h0E: dec7 = 5'h0F;
      7'h7F: dec7 = 5'h10;
      default: dec7 = 5'h1F;
    endcase
  endfunction

  logic [3:0][4:0] dsym;
  logic [3:0]      dbad;

  for (genvar i = 0; i < 4; i++) begin : g_dec
    assign dsym[i] = dec7(hex_in[7*i +: 7]);
    assign dbad[i] = (dsym[i] == 5'h1F);
  end

  logic bad;
  logic is_static, is_rr, is_rl;
  logic classify, c_rr, c_rl, c_jump, c_rot;

  assign bad       = |dbad;
  assign is_static = (hex_in == prev);
  assign is_rr     = (hex_in == {prev[6:0], prev[27:7]});
  assign is_rl     = (hex_in == {prev[20:0], prev[27:21]});

  // The first frame after reset has nothing to compare against.
  assign classify = (state != EMPTY);
  assign c_rr     = classify && !is_static && is_rr;
  assign c_rl     = classify && !is_static && !is_rr && is_rl;
  assign c_jump   = classify && !is_static && !is_rr && !is_rl;
  assign c_rot    = c_rr || c_rl;

  // Next-state logic; only consumed on tick cycles.
  always_comb begin
    state_nx  = state;
    streak_nx = streak;
    dir_nx    = dir;
    if (bad) begin
      state_nx  = ERROR;
      streak_nx = 2'd0;
    end else begin
      case (state)
        EMPTY, ERROR: begin
          state_nx  = TRACK;
          streak_nx = 2'd0;
        end
        TRACK: begin
          if (c_rot) begin
            if (streak != 2'd0 && dir == c_rr) begin
              // streak holds 1..3; the 4th same-direction step locks
              if (streak == 2'd3) state_nx = LOCKED;
              else                streak_nx = streak + 2'd1;
            end else begin
              streak_nx = 2'd1;
              dir_nx    = c_rr;
            end
          end else begin
            streak_nx = 2'd0;
          end
        end
        LOCKED: begin
          if (c_rot && dir == c_rr) begin
            state_nx = LOCKED;
          end else if (c_rot) begin
            state_nx  = TRACK;
            streak_nx = 2'd1;
            dir_nx    = c_rr;
          end else begin
            state_nx  = TRACK;
            streak_nx = 2'd0;
          end
        end
        default: begin
          state_nx  = EMPTY;
          streak_nx = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      streak <= 2'd0;
      dir    <= 1'b0;
    end else if (tick) begin
      state  <= state_nx;
      streak <= streak_nx;
      dir    <= dir_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev        <= '0;
      sym3        <= 5'h10;
      sym2        <= 5'h10;
      sym1        <= 5'h10;
      sym0        <= 5'h10;
      frame_valid <= 1'b0;
      rot_r       <= 1'b0;
      rot_l       <= 1'b0;
      jump        <= 1'b0;
      bad_code    <= 1'b0;
      locked      <= 1'b0;
      phase       <= 2'd0;
      rot_count   <= 8'd0;
    end else begin
      frame_valid <= 1'b0;
      rot_r       <= 1'b0;
      rot_l       <= 1'b0;
      jump        <= 1'b0;
      if (tick) begin
        prev        <= hex_in;
        sym3        <= dsym[3];
        sym2        <= dsym[2];
        sym1        <= dsym[1];
        sym0        <= dsym[0];
        frame_valid <= 1'b1;
        rot_r       <= c_rr;
        rot_l       <= c_rl;
        jump        <= c_jump;
        bad_code    <= bad;
        locked      <= (state_nx == LOCKED);
        if (!classify)  phase <= 2'd0;
        else if (c_rr)  phase <= phase + 2'd1;
        else if (c_rl)  phase <= phase - 2'd1;
        if (c_rot) rot_count <= rot_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hex_rotate_monitor.sv
// tb_hex_rotate_monitor
//   Directed scenarios plus randomized frames, every output compared after
//   each tick (and on idle cycles) against a behavioural model that tracks
//   the run of same-direction rotations as a plain integer.
module tb_hex_rotate_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [27:0] hex_in = '0;
  logic [4:0]  sym3, sym2, sym1, sym0;
  logic        frame_valid, rot_r, rot_l, jump, bad_code, locked;
  logic [1:0]  phase;
  logic [7:0]  rot_count;

  hex_rotate_monitor dut (
    .clk(clk), .reset(reset), .tick(tick), .hex_in(hex_in),
    .sym3(sym3), .sym2(sym2), .sym1(sym1), .sym0(sym0),
    .frame_valid(frame_valid), .rot_r(rot_r), .rot_l(rot_l), .jump(jump),
    .bad_code(bad_code), .locked(locked), .phase(phase), .rot_count(rot_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] codes [0:16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                               7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21,
                               7'h06, 7'h0E, 7'h7F};

  bit         m_first, m_err, m_locked, m_bad, m_dir;
  bit         e_fv, e_rr, e_rl, e_j;
  int         m_run, m_phase, m_cnt;
  logic [27:0] m_p;
  int         e_sym [4];

  function automatic int m_dec(input logic [6:0] c);
    for (int i = 0; i < 16; i++) if (c == codes[i]) return i;
    if (c == 7'h7F) return 16;
    return 31;
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] p);
    return {p[6:0], p[27:7]};
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] p);
    return {p[20:0], p[27:21]};
  endfunction

  task automatic m_reset();
    m_first = 1; m_err = 0; m_locked = 0; m_bad = 0; m_dir = 0;
    m_run = 0; m_phase = 0; m_cnt = 0; m_p = '0;
    e_fv = 0; e_rr = 0; e_rl = 0; e_j = 0;
    for (int i = 0; i < 4; i++) e_sym[i] = 16;
  endtask

  task automatic m_tick(input logic [27:0] n);
    bit b, r, l;
    b = 0;
    for (int i = 0; i < 4; i++) begin
      e_sym[i] = m_dec(n[7*i +: 7]);
      if (e_sym[i] == 31) b = 1;
    end
    e_fv = 1; e_rr = 0; e_rl = 0; e_j = 0;
    if (m_first) begin
      m_first = 0; m_phase = 0; m_run = 0; m_locked = 0; m_err = b;
    end else begin
      r = 0; l = 0;
      if (n == m_p) ;
      else if (n == rotr(m_p)) r = 1;
      else if (n == rotl(m_p)) l = 1;
      else e_j = 1;
      e_rr = r; e_rl = l;
      if (r) m_phase = (m_phase + 1) % 4;
      if (l) m_phase = (m_phase + 3) % 4;
      if (r || l) m_cnt = (m_cnt + 1) % 256;
      if (b) begin
        m_err = 1; m_locked = 0; m_run = 0;
      end else if (m_err) begin
        m_err = 0; m_locked = 0; m_run = 0;
      end else if (r || l) begin
        if (m_run > 0 && m_dir == r) m_run++;
        else begin m_run = 1; m_dir = r; end
        if (m_run > 8) m_run = 8;
        m_locked = (m_run >= 4);
      end else begin
        m_run = 0; m_locked = 0;
      end
    end
    m_bad = b;
    m_p = n;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sym3"}, int'(sym3), e_sym[3]);
    chk({tag, ".sym2"}, int'(sym2), e_sym[2]);
    chk({tag, ".sym1"}, int'(sym1), e_sym[1]);
    chk({tag, ".sym0"}, int'(sym0), e_sym[0]);
    chk({tag, ".frame_valid"}, int'(frame_valid), int'(e_fv));
    chk({tag, ".rot_r"}, int'(rot_r), int'(e_rr));
    chk({tag, ".rot_l"}, int'(rot_l), int'(e_rl));
    chk({tag, ".jump"}, int'(jump), int'(e_j));
    chk({tag, ".bad_code"}, int'(bad_code), int'(m_bad));
    chk({tag, ".locked"}, int'(locked), int'(m_locked));
    chk({tag, ".phase"}, int'(phase), m_phase);
    chk({tag, ".rot_count"}, int'(rot_count), m_cnt);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_tick(input string tag, input logic [27:0] f, input int idle);
    @(negedge clk);
    hex_in = f; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0; hex_in = 28'($urandom);
    m_tick(f);
    check_all(tag);
    e_fv = 0; e_rr = 0; e_rl = 0; e_j = 0;
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      check_all({tag, ".idle"});
    end
  endtask

  task automatic do_reset(input string tag, input bit with_tick);
    @(negedge clk);
    reset = 1'b1; tick = with_tick; hex_in = 28'($urandom);
    @(negedge clk);
    reset = 1'b0; tick = 1'b0;
    m_reset();
    check_all(tag);
  endtask

  function automatic logic [27:0] rand_valid();
    logic [27:0] f;
    for (int i = 0; i < 4; i++) f[7*i +: 7] = codes[$urandom_range(0, 16)];
    return f;
  endfunction

  logic [27:0] f0, f;

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_all("reset");

    // decode sweep on HEX0, other digits show 0
    for (int i = 0; i < 17; i++) do_tick("decode", {21'h102040, codes[i]}, 0);
    do_tick("decode_bad", {21'h102040, 7'h55}, 1);
    chk("decode_bad.sym0", int'(sym0), 31);
    chk("decode_bad.bad_code", int'(bad_code), 1);

    // steady right rotation locks after the 4th step
    do_reset("rst_rot", 0);
    f0 = {7'h79, 7'h24, 7'h30, 7'h19};
    do_tick("rot_first", f0, 1);
    f = f0;
    for (int i = 0; i < 4; i++) begin
      f = rotr(f);
      do_tick("rot_r", f, 0);
      chk("rot_r.phase_seq", int'(phase), (i + 1) % 4);
    end
    chk("rot_r.locked", int'(locked), 1);
    chk("rot_r.count", int'(rot_count), 4);

    // jump breaks lock, then one left rotation
    do_tick("jump", {4{7'h00}}, 0);
    chk("jump.locked", int'(locked), 0);
    f = {7'h00, 7'h79, 7'h00, 7'h00};
    do_tick("pre_l", f, 0);
    do_tick("rot_l", rotl(f), 1);
    chk("rot_l.phase", int'(phase), 3);

    // static frames produce no events
    do_reset("rst_static", 0);
    for (int i = 0; i < 4; i++) do_tick("static", {4{7'h40}}, 1);
    chk("static.count", int'(rot_count), 0);

    // error recovery from locked
    do_reset("rst_err", 0);
    f = f0;
    do_tick("err_first", f, 0);
    for (int i = 0; i < 4; i++) begin f = rotr(f); do_tick("err_lock", f, 0); end
    do_tick("err_bad", {f[27:7], 7'h55}, 0);
    chk("err_bad.locked", int'(locked), 0);
    do_tick("err_recover", f, 1);
    chk("err_recover.bad_code", int'(bad_code), 0);

    // 255 rotations, then reset coincident with tick
    do_reset("rst_wrap", 0);
    f = f0;
    do_tick("wrap_first", f, 0);
    for (int i = 0; i < 255; i++) begin f = rotl(f); do_tick("wrap_rot", f, 0); end
    chk("wrap.count255", int'(rot_count), 255);
    do_reset("rst_coincident", 1);
    do_tick("post_rst", rotl(f), 0);
    chk("post_rst.rot_l", int'(rot_l), 0);
    f = rotl(f);
    for (int i = 0; i < 256; i++) begin f = rotr(f); do_tick("wrap2", f, 0); end
    chk("wrap.count0", int'(rot_count), 0);

    // randomized frames
    do_reset("rst_rand", 0);
    f = rand_valid();
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 9))
        0:       f = f;
        1, 2, 3: f = rotr(f);
        4, 5:    f = rotl(f);
        6:       f = rand_valid();
        7:       f[7*$urandom_range(0, 3) +: 7] = 7'($urandom);
        8:       if ($urandom_range(0, 3) == 0) do_reset("rand_rst", $urandom_range(0, 1) == 1);
        default: f = rotr(f);
      endcase
      do_tick("rand", f, $urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/hex_rotate_monitor.md
HEX_ROTATE_MONITOR -- requirements
Module: hex_rotate_monitor

Interface
REQ-001 SHALL have port: clk  in  1  single system clock, all logic on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: tick  in  1  one-clk sample strobe (e.g. 1 s enable); hex_in is ignored when low.
REQ-004 SHALL have port: hex_in  in  28  four active-low 7-seg codes; [27:21]=HEX3, [20:14]=HEX2, [13:7]=HEX1, [6:0]=HEX0; per digit bit6..0 = g,f,e,d,c,b,a.
REQ-005 SHALL have ports: sym3, sym2, sym1, sym0  out  5 each  decoded symbol per digit.
REQ-006 SHALL have port: frame_valid  out  1  one-clk pulse, new decode result available.
REQ-007 SHALL have ports: rot_r, rot_l, jump  out  1 each  one-clk classification pulses, coincident with frame_valid.
REQ-008 SHALL have port: bad_code  out  1  level, last sampled frame held an undecodable digit.
REQ-009 SHALL have port: locked  out  1  level, steady rotation detected.
REQ-010 SHALL have port: phase  out  2  digit offset of current frame relative to first captured frame.
REQ-011 SHALL have port: rot_count  out  8  total rotations (either direction) since reset.

Function
REQ-012 SHALL decode each digit as: 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x10->9, 0x08->A, 0x03->B, 0x46->C, 0x21->D, 0x06->E, 0x0E->F (5'h00-5'h0F), 0x7F->5'h10 (blank), any other->5'h1F.
REQ-013 SHALL register sym3..sym0, classification pulses, frame_valid and all status exactly 1 clk after the tick cycle; no output changes in cycles without a preceding tick.
REQ-014 SHALL hold previous frame P (28 bits) and classify new frame N, priority: static (N==P) > rot_r (N=={P[6:0],P[27:7]}) > rot_l (N=={P[20:0],P[27:21]}) > jump.
REQ-015 SHALL classify no event on the first tick after reset (frame captured only; frame_valid pulses, rot_r/rot_l/jump low).
REQ-016 SHALL update P with N on every tick, including bad and jump frames.
REQ-017 SHALL increment phase (mod 4) on rot_r, decrement (mod 4) on rot_l, hold otherwise; phase=0 on first captured frame.
REQ-018 SHALL increment rot_count on rot_r or rot_l, wrapping 255->0.
REQ-019 SHALL implement FSM states EMPTY, TRACK, LOCKED, ERROR with 2-bit streak counter and direction bit.
REQ-020 EMPTY: tick -> TRACK (or ERROR if any digit 5'h1F), streak=0.
REQ-021 TRACK: rotation same direction as last rotation -> streak+1, at 4th consecutive -> LOCKED; opposite direction -> streak=1, direction updated; static or jump -> streak=0.
REQ-022 LOCKED: same-direction rotation -> stay; static, jump or opposite rotation -> TRACK, streak=0 (opposite rotation then counts as streak=1).
REQ-023 Any state: tick with any digit 5'h1F -> ERROR, bad_code=1, locked=0; classification still reported and phase/rot_count still updated.
REQ-024 ERROR: tick with all digits decodable -> TRACK, streak=0, bad_code=0.
REQ-025 locked SHALL equal (state==LOCKED), registered.

Reset
REQ-026 SHALL on reset: state EMPTY, P=0, sym*=5'h10, all pulses 0, bad_code=0, locked=0, phase=0, rot_count=0, streak=0.
REQ-027 SHALL give reset priority over a coincident tick; that tick's frame is discarded.
REQ-028 SHALL treat reset mid-sequence identically to power-up reset; next tick is a first-capture.

Verification
REQ-029 Decode sweep: tick with each of the 16 hex codes plus 0x7F and 0x55 in HEX0 -> sym0 = 0x00..0x0F, 0x10, 0x1F; 0x55 sets bad_code.
REQ-030 Right rotation: frame {0x79,0x24,0x30,0x19} then 4 ticks each rotating right -> rot_r pulses x4, phase 1,2,3,0, rot_count=4, locked rises after 4th.
REQ-031 Break lock: locked, then tick with a jump frame -> jump=1, locked=0, state TRACK; then one rot_l -> streak=1, phase decrements.
REQ-032 Static/ambiguous: all digits 0x40, repeated ticks -> static only (no pulses except frame_valid), rot_count unchanged.
REQ-033 Error recovery: locked, tick with digit 0x55 -> bad_code=1, locked=0; next tick valid frame -> bad_code=0, TRACK.
REQ-034 Reset coincident with tick while locked and rot_count=255 -> all outputs reset values, next tick produces no classification; rot_count wrap checked separately 255->0.
